// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the flag-update controller
package cpu_pkg;

  // alu_op_class encodings: which flags an ALU result touches
  localparam logic [1:0] FLG_NONE  = 2'b00;
  localparam logic [1:0] FLG_ADD   = 2'b01;
  localparam logic [1:0] FLG_SUB   = 2'b10;
  localparam logic [1:0] FLG_LOGIC = 2'b11;

  // Bit positions inside every {C,Z,B} triple
  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_B = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_RESTORE = 2'd2
  } flag_state_e;

endpackage

// File: rtl/cpu_flag_lifo.sv
// rtl/cpu_flag_lifo.sv - 3-bit-wide flag-save LIFO with registered read data
module cpu_flag_lifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] wr_data,
  output logic [2:0] rd_data,
  output logic       empty,
  output logic       full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_FULL = DEPTH[PW:0];
  localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};

  // ptr counts stored entries; it is one wider than the index so full is distinguishable
  logic [PW:0]   ptr;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;
  logic [PW:0]   ptr_dec;

  assign ptr_dec = ptr - PTR_ONE;
  assign wr_idx  = ptr[PW-1:0];
  assign top_idx = ptr_dec[PW-1:0];
  assign empty   = (ptr == '0);
  assign full    = (ptr == PTR_FULL);

  // Pointer and read register; resetting the pointer discards every saved entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr     <= '0;
      rd_data <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_ONE;
    end else if (pop && !empty) begin
      ptr     <= ptr_dec;
      rd_data <= mem[top_idx];
    end
  end

  // Storage array; contents beyond the pointer are don't-care so it needs no reset
  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/cpu_flag_ctrl.sv
// rtl/cpu_flag_ctrl.sv - C/Z/B flag-update controller with interrupt save/restore (CPU_FLAGCTRL_STACK_EN)
module cpu_flag_ctrl
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       alu_valid,
  input  logic [1:0] alu_op_class,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_b,
  input  logic       flag_wr,
  input  logic [2:0] flag_wr_mask,
  input  logic [2:0] flag_wr_val,
  input  logic       irq_entry,
  input  logic       irq_return,
  input  logic       C,
  input  logic       Z,
  input  logic       B,
  output logic       Cin,
  output logic       Zin,
  output logic       Bin,
  output logic       EN_C,
  output logic       EN_B,
  output logic       busy,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err
);

  // Next-flag candidates for the IDLE state
  logic n_c, n_z, n_b, n_en_c, n_en_b;

  // Explicit write beats the ALU; anything not written is fed back unchanged
  always_comb begin
    n_c    = C;
    n_z    = Z;
    n_b    = B;
    n_en_c = 1'b0;
    n_en_b = 1'b0;
    if (flag_wr) begin
      if (flag_wr_mask[FLG_C]) begin
        n_c    = flag_wr_val[FLG_C];
        n_en_c = 1'b1;
      end
      if (flag_wr_mask[FLG_Z]) begin
        n_z = flag_wr_val[FLG_Z];
      end
      if (flag_wr_mask[FLG_B]) begin
        n_b    = flag_wr_val[FLG_B];
        n_en_b = 1'b1;
      end
    end else if (alu_valid) begin
      case (alu_op_class)
        FLG_ADD: begin
          n_c    = alu_c;
          n_en_c = 1'b1;
          n_z    = alu_z;
        end
        FLG_SUB: begin
          n_b    = alu_b;
          n_en_b = 1'b1;
          n_z    = alu_z;
        end
        FLG_LOGIC: n_z = alu_z;
        default: ;
      endcase
    end
  end

`ifdef CPU_FLAGCTRL_STACK_EN
  flag_state_e state;
  logic        lifo_push;
  logic        lifo_pop;
  logic [2:0]  lifo_rd;
  logic        lifo_empty;
  logic        lifo_full;

  // A return in the same cycle swallows the entry; pre-update flags are saved
  assign lifo_push = (state == ST_IDLE) && irq_entry && !irq_return;
  assign lifo_pop  = (state == ST_POP);

  cpu_flag_lifo #(
    .DEPTH(STACK_DEPTH)
  ) u_lifo (
    .CLK    (CLK),
    .RST    (RST),
    .push   (lifo_push),
    .pop    (lifo_pop),
    .wr_data({C, Z, B}),
    .rd_data(lifo_rd),
    .empty  (lifo_empty),
    .full   (lifo_full)
  );

  assign stk_empty = lifo_empty;
  assign stk_full  = lifo_full;

  // Restore sequencer: POP reads the LIFO, RESTORE drives the popped flags
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (irq_return) begin
            if (lifo_empty) begin
              stk_err <= 1'b1;
            end else begin
              state <= ST_POP;
              busy  <= 1'b1;
            end
          end else if (irq_entry && lifo_full) begin
            stk_err <= 1'b1;
          end
        end
        ST_POP: state <= ST_RESTORE;
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_irq;
  localparam int unused_depth = STACK_DEPTH;

  assign unused_irq = irq_entry ^ irq_return;
  assign busy       = 1'b0;
  assign stk_empty  = 1'b1;
  assign stk_full   = 1'b0;
  assign stk_err    = 1'b0;
`endif

  // Drive cpu_mreg: state overrides first, reset forces the quiescent pattern last
  always_comb begin
    Cin  = n_c;
    Zin  = n_z;
    Bin  = n_b;
    EN_C = n_en_c;
    EN_B = n_en_b;
`ifdef CPU_FLAGCTRL_STACK_EN
    if (state == ST_RESTORE) begin
      Cin  = lifo_rd[FLG_C];
      Zin  = lifo_rd[FLG_Z];
      Bin  = lifo_rd[FLG_B];
      EN_C = 1'b1;
      EN_B = 1'b1;
    end else if (state == ST_POP) begin
      Cin  = C;
      Zin  = Z;
      Bin  = B;
      EN_C = 1'b0;
      EN_B = 1'b0;
    end
`endif
    if (!RST) begin
      Cin  = 1'b0;
      Zin  = Z;
      Bin  = 1'b0;
      EN_C = 1'b0;
      EN_B = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_flag_ctrl.sv
// tb/tb_cpu_flag_ctrl.sv - randomized self-checking bench for cpu_flag_ctrl
module tb_cpu_flag_ctrl;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       alu_valid, alu_c, alu_z, alu_b, flag_wr, irq_entry, irq_return;
  logic [1:0] alu_op_class;
  logic [2:0] flag_wr_mask, flag_wr_val;
  logic       C, Z, B;
  logic       Cin, Zin, Bin, EN_C, EN_B, busy, stk_empty, stk_full, stk_err;
  logic [2:0] init_flags;

  int checks = 0;
  int failures = 0;

  // Reference state: flags, saved-flag stack, restore phase, sticky error
  logic       mc, mz, mb, merr;
  logic [2:0] mq[$];
  logic [2:0] popped;
  int         phase;
  logic       e_c, e_z, e_b, e_enc, e_enb;

  cpu_flag_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .alu_valid(alu_valid), .alu_op_class(alu_op_class),
    .alu_c(alu_c), .alu_z(alu_z), .alu_b(alu_b), .flag_wr(flag_wr),
    .flag_wr_mask(flag_wr_mask), .flag_wr_val(flag_wr_val),
    .irq_entry(irq_entry), .irq_return(irq_return), .C(C), .Z(Z), .B(B),
    .Cin(Cin), .Zin(Zin), .Bin(Bin), .EN_C(EN_C), .EN_B(EN_B), .busy(busy),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  always #5 CLK = ~CLK;

  // cpu_mreg stand-in: Z loads every clock, C and B only when enabled
  always @(posedge CLK) begin
    if (!RST) begin
      {C, Z, B} <= init_flags;
    end else begin
      if (EN_C) C <= Cin;
      Z <= Zin;
      if (EN_B) B <= Bin;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] f);
    init_flags = f;
    RST = 1'b0;
    {alu_valid, alu_op_class, alu_c, alu_z, alu_b} = '0;
    {flag_wr, flag_wr_mask, flag_wr_val, irq_entry, irq_return} = '0;
    mq.delete();
    phase = 0;
    merr = 1'b0;
    {mc, mz, mb} = f;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("reset_drive", {3'b0, Cin, Zin, Bin, EN_C, EN_B}, {3'b0, 1'b0, f[1], 1'b0, 2'b00});
    check("reset_status", {4'b0, busy, stk_empty, stk_full, stk_err}, 8'b0000_0100);
    RST = 1'b1;
    #1;
  endtask

  // One clock: drive, check combinational drive, advance model, check registered view
  task automatic cyc(input logic av, input logic [1:0] cls, input logic [2:0] alu,
                     input logic fw, input logic [2:0] m, input logic [2:0] v,
                     input logic ie, input logic ir);
    alu_valid = av; alu_op_class = cls; {alu_c, alu_z, alu_b} = alu;
    flag_wr = fw; flag_wr_mask = m; flag_wr_val = v;
    irq_entry = ie; irq_return = ir;
    #3;
    {e_c, e_z, e_b, e_enc, e_enb} = {mc, mz, mb, 2'b00};
    if (phase == 2) begin
      {e_c, e_z, e_b, e_enc, e_enb} = {popped, 2'b11};
    end else if (phase == 0 && fw) begin
      if (m[2]) {e_c, e_enc} = {v[2], 1'b1};
      if (m[1]) e_z = v[1];
      if (m[0]) {e_b, e_enb} = {v[0], 1'b1};
    end else if (phase == 0 && av) begin
      if (cls == 2'd1) {e_c, e_enc, e_z} = {alu[2], 1'b1, alu[1]};
      if (cls == 2'd2) {e_b, e_enb, e_z} = {alu[0], 1'b1, alu[1]};
      if (cls == 2'd3) e_z = alu[1];
    end
    check("drive", {3'b0, Cin, Zin, Bin, EN_C, EN_B}, {3'b0, e_c, e_z, e_b, e_enc, e_enb});
    @(posedge CLK);
`ifdef CPU_FLAGCTRL_STACK_EN
    if (phase == 0) begin
      if (ir) begin
        if (mq.size() == 0) merr = 1'b1;
        else phase = 1;
      end else if (ie) begin
        if (mq.size() == DEPTH) merr = 1'b1;
        else mq.push_back({mc, mz, mb});
      end
    end else if (phase == 1) begin
      popped = mq.pop_back();
      phase = 2;
    end else begin
      phase = 0;
    end
`endif
    if (e_enc) mc = e_c;
    mz = e_z;
    if (e_enb) mb = e_b;
    #1;
    check("flags", {5'b0, C, Z, B}, {5'b0, mc, mz, mb});
    check("status", {4'b0, busy, stk_empty, stk_full, stk_err},
          {4'b0, phase != 0, mq.size() == 0, mq.size() == DEPTH, merr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
  endtask

  initial begin
    do_reset(3'b010);

    // ADD: C=1, Z=0
    cyc(1, 2'd1, 3'b100, 0, 3'd0, 3'd0, 0, 0);
    check("add_cz", {6'b0, C, Z}, 8'b10);

    // explicit write beats ALU: C=0, B=1, Z held at 0
    cyc(1, 2'd1, 3'b010, 1, 3'b101, 3'b001, 0, 0);
    check("wr_wins", {5'b0, C, Z, B}, 8'b001);

    // save 1,0,1, clear via ALU, restore
    cyc(0, 2'd0, 3'd0, 1, 3'b111, 3'b101, 0, 0);
    cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 1, 0);
    cyc(1, 2'd1, 3'b000, 0, 3'd0, 3'd0, 0, 0);
    cyc(1, 2'd2, 3'b000, 0, 3'd0, 3'd0, 0, 0);
    check("cleared", {5'b0, C, Z, B}, 8'b000);
    cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 0, 1);
    idle(3);
`ifdef CPU_FLAGCTRL_STACK_EN
    check("restored", {5'b0, C, Z, B}, 8'b101);
`else
    check("no_restore", {5'b0, C, Z, B}, 8'b000);
`endif

    // reset in the middle of a restore
    cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 1, 0);
    cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 0, 1);
    RST = 1'b0;
    #1;
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_empty", {7'b0, stk_empty}, 8'd1);
    do_reset({mc, mz, mb});

    // five pushes into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'd0, 3'd0, 1, 3'b111, 3'(i), 1, 0);
`ifdef CPU_FLAGCTRL_STACK_EN
      if (i == 3) check("full_after4", {6'b0, stk_full, stk_err}, 8'b10);
      if (i == 4) check("err_after5", {6'b0, stk_full, stk_err}, 8'b11);
`endif
    end
    idle(1);

    // return on an empty stack
    do_reset(3'b101);
    cyc(0, 2'd0, 3'd0, 0, 3'd0, 3'd0, 0, 1);
`ifdef CPU_FLAGCTRL_STACK_EN
    check("empty_ret", {6'b0, busy, stk_err}, 8'b01);
`else
    check("empty_ret", {6'b0, busy, stk_err}, 8'b00);
`endif

    // randomized traffic against the model
    do_reset(3'($urandom_range(0, 7)));
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      if (i == 300) do_reset(3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_flag_ctrl.md
# cpu_flag_ctrl

Flag-update controller sitting between the decoder/ALU and `cpu_mreg`. It decides each cycle which of the C/Z/B flags change and drives `cpu_mreg`'s `Cin`/`Zin`/`Bin`/`EN_C`/`EN_B` inputs accordingly. It also saves and restores the flags across interrupt entry and return, using a small LIFO. `cpu_mreg` loads Z every clock, so this block must feed the current Z back whenever Z is not being updated.

## Interface
- `STACK_DEPTH`, 4: flag-save LIFO entries, ≥2, power of two.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid this cycle.
- `alu_op_class`  in  2  flag class:
  - 00 = none
  - 01 = add (C, Z)
  - 10 = sub (B, Z)
  - 11 = logic (Z only)
- `alu_c`, `alu_z`, `alu_b`  in  1 each  ALU flag results.
- `flag_wr`  in  1  explicit flag-write instruction.
- `flag_wr_mask`  in  3  {C,Z,B} bits to overwrite.
- `flag_wr_val`  in  3  {C,Z,B} new values.
- `irq_entry`  in  1  push current flags (one-cycle pulse).
- `irq_return`  in  1  pop and restore flags (one-cycle pulse).
- `C`, `Z`, `B`  in  1 each  committed flags from `cpu_mreg`.
- `Cin`, `Zin`, `Bin`  out  1 each  next-flag values to `cpu_mreg`.
- `EN_C`, `EN_B`  out  1 each  load enables to `cpu_mreg`.
- `busy`  out  1  restore in progress; the decoder stalls.
- `stk_empty`, `stk_full`  out  1 each  LIFO status.
- `stk_err`  out  1  sticky error: overflow or underflow.

## Operation
- FSM states:
  - IDLE → POP on `irq_return` while `!stk_empty`.
  - POP → RESTORE unconditionally; this is the LIFO read cycle.
  - RESTORE → IDLE unconditionally.
- Source priority in IDLE: `flag_wr` > `alu_valid`.
- ALU update in IDLE:
  - class 01: `Cin=alu_c`, `EN_C=1`, `Zin=alu_z`.
  - class 10: `Bin=alu_b`, `EN_B=1`, `Zin=alu_z`.
  - class 11: `Zin=alu_z` only.
  - class 00: no change.
- Explicit write: each masked bit drives its value and its enable; for Z, `Zin=flag_wr_val[1]`. Unmasked bits are held.
- Default, whenever Z is not written: `Zin=Z`, `Cin=C`, `Bin=B`, `EN_C=EN_B=0`.
- Push on `irq_entry` in IDLE: write the committed {C,Z,B} to the LIFO and increment the pointer. An ALU or explicit update in the same cycle still applies; the pre-update flags are what get saved.
- Push when full: the push is dropped, `stk_err` is set, and the pointer is unchanged.
- `irq_return` when empty: ignored, `stk_err` is set, FSM stays in IDLE.
- In RESTORE: drive the popped {C,Z,B} with `EN_C=EN_B=1` and `Zin`=popped Z. `alu_valid`, `flag_wr` and `irq_*` are ignored.
- `irq_entry` and `irq_return` asserted in the same cycle: return wins and the entry is dropped; `stk_err` is not set.
- `stk_err` clears only on reset.

## Timing
- Reset values:
  - `EN_C=EN_B=0`, `Cin=Bin=0`, `Zin=Z`.
  - `busy=0`, `stk_empty=1`, `stk_full=0`, `stk_err=0`.
  - pointer=0, FSM=IDLE.
- ALU and explicit updates are combinational to `cpu_mreg`; flags are visible on C/Z/B one edge later.
- Restore latency: `irq_return` at edge N → `busy` high in cycles N+1 and N+2 → restored flags at `cpu_mreg` outputs after edge N+3.
- Reset asserted mid-restore: the FSM returns to IDLE, the LIFO contents are discarded, and `busy` drops immediately.

## Configuration
- `CPU_FLAGCTRL_STACK_EN` defined: LIFO and POP/RESTORE states are present, as described above.
- `CPU_FLAGCTRL_STACK_EN` undefined:
  - LIFO and POP/RESTORE are removed; `irq_entry` and `irq_return` are ignored.
  - `busy=0`, `stk_empty=1`, `stk_full=0`, `stk_err=0` constantly.

## Structure
- `cpu_pkg` holds:
  - the `alu_op_class` encodings (`FLG_NONE`, `FLG_ADD`, `FLG_SUB`, `FLG_LOGIC`);
  - the flag bit indices (`FLG_C=2`, `FLG_Z=1`, `FLG_B=0`);
  - the FSM state enum.
- Sub-module `cpu_flag_lifo`: parameterised 3-bit-wide LIFO with push, pop, empty, full and registered read data.

## Test plan
- Reset with Z=1 → `Zin`=1, `EN_C=EN_B=0`, `stk_empty=1`.
- `alu_valid`, class 01, `alu_c=1`, `alu_z=0` → `EN_C=1`, `Cin=1`, `Zin=0`; after the edge, C=1 and Z=0.
- `flag_wr`, mask 3'b101, val 3'b001, together with `alu_valid` → explicit write wins: C=0, B=1, Z unchanged.
- C,Z,B=1,0,1, `irq_entry`, then ALU clears all flags, then `irq_return` → `busy` high for 2 cycles, then C,Z,B=1,0,1.
- 5 pushes with `STACK_DEPTH=4` → `stk_full=1` after the 4th push, `stk_err=1` after the 5th.
- `irq_return` on an empty stack → no `busy`, `stk_err=1`.
